mem_io_responder: RTL and testbench

- Memory-side end of the CPU byte bus (mem_a/mem_wr/mem_dout from CPU, mem_din back to CPU).
- Services a 128KB byte RAM and the I/O window at 0x30000: UART RX/TX byte FIFOs, a free-running cycle counter and a program-halt flag.
- Drives the CPU's rdy_in, stalling it while an I/O access cannot complete.
- Sits in the top-level testbench/SoC wrapper between cpu, the UART blocks and the RAM.

---
 rtl/mem_io_responder_if.sv | 12 +
 rtl/mem_io_responder.sv | 141 ++++++++++++++
 tb/tb_mem_io_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// CPU byte-bus between the core and its memory-side responder.
// The master drives address/command/write data; the slave returns read data and ready.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        rdy_out;

    modport master (output mem_a, output mem_wr, output mem_dout, input mem_din, input rdy_out);
    modport slave  (input mem_a, input mem_wr, input mem_dout, output mem_din, output rdy_out);
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: 128KB byte RAM plus an I/O window with UART FIFOs,
// cycle counter snapshot and a sticky halt flag; stalls the CPU on blocked I/O.
module mem_io_responder #(
    parameter int RAM_ADDR_W      = 17,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_responder_if.slave bus,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              halt
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2 + 1;

    logic [7:0]  ram_q    [0:(1<<RAM_ADDR_W)-1];
    logic [7:0]  rx_mem_q [0:DEPTH-1];
    logic [7:0]  tx_mem_q [0:DEPTH-1];

    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic [31:0]   cnt_q, cnt_d, snap_q, snap_d;
    logic          halt_q, halt_d;

    logic                  io_s, rdy_s, acc_s, rd_acc_s;
    logic [2:0]            reg_s;
    logic [RAM_ADDR_W-1:0] ram_idx_s;
    logic                  rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic                  rx_push_s, rx_pop_s, tx_push_s, tx_pop_s, ram_we_s;
    logic [7:0]            tx_wdata_s;
    logic                  unused_s;

    assign unused_s = ^bus.mem_a[31:18];

    // Address decode, FIFO flags and the CPU stall condition.
    always_comb begin
        io_s       = (bus.mem_a[17:16] == 2'b11);
        reg_s      = bus.mem_a[2:0];
        ram_idx_s  = bus.mem_a[RAM_ADDR_W-1:0];
        rx_empty_s = (rx_wp_q == rx_rp_q);
        rx_full_s  = (rx_wp_q[PW-1] != rx_rp_q[PW-1]) && (rx_wp_q[PW-2:0] == rx_rp_q[PW-2:0]);
        tx_empty_s = (tx_wp_q == tx_rp_q);
        tx_full_s  = (tx_wp_q[PW-1] != tx_rp_q[PW-1]) && (tx_wp_q[PW-2:0] == tx_rp_q[PW-2:0]);
        rdy_s = !(io_s && !bus.mem_wr && (reg_s == 3'd0) && rx_empty_s)
             && !(io_s &&  bus.mem_wr && (reg_s == 3'd0) && (bus.mem_dout != 8'h00) && tx_full_s)
             && !(io_s &&  bus.mem_wr && (reg_s == 3'd4) && tx_full_s);
        acc_s      = rdy_s && rst_in;
        rd_acc_s   = acc_s && !bus.mem_wr;
        ram_we_s   = acc_s && bus.mem_wr && !io_s;
        rx_push_s  = rx_valid && !rx_full_s && rst_in;
        rx_pop_s   = rd_acc_s && io_s && (reg_s == 3'd0);
        tx_pop_s   = !tx_empty_s && tx_ready && rst_in;
        // Once halted, every I/O write is dropped, including the halt register itself.
        tx_push_s  = acc_s && bus.mem_wr && io_s && !halt_q &&
                     (((reg_s == 3'd0) && (bus.mem_dout != 8'h00)) || (reg_s == 3'd4));
        tx_wdata_s = (reg_s == 3'd4) ? 8'h00 : bus.mem_dout;
    end

    // Next-state for read data, counter, snapshot, halt and FIFO pointers.
    always_comb begin
        mem_din_d = mem_din_q;
        snap_d    = snap_q;
        halt_d    = halt_q;
        cnt_d     = cnt_q + 32'd1;
        rx_wp_d   = rx_wp_q + PW'(rx_push_s);
        rx_rp_d   = rx_rp_q + PW'(rx_pop_s);
        tx_wp_d   = tx_wp_q + PW'(tx_push_s);
        tx_rp_d   = tx_rp_q + PW'(tx_pop_s);
        if (rd_acc_s && !io_s) begin
            mem_din_d = ram_q[ram_idx_s];
        end else if (rd_acc_s) begin
            case (reg_s)
                3'd0: mem_din_d = rx_mem_q[rx_rp_q[PW-2:0]];
                3'd4: begin
                    mem_din_d = cnt_q[7:0];
                    snap_d    = cnt_q;
                end
                3'd5:    mem_din_d = snap_q[15:8];
                3'd6:    mem_din_d = snap_q[23:16];
                3'd7:    mem_din_d = snap_q[31:24];
                default: mem_din_d = 8'h00;
            endcase
        end else begin
            mem_din_d = mem_din_q;
        end
        if (tx_push_s && (reg_s == 3'd4)) begin
            halt_d = 1'b1;
        end else begin
            halt_d = halt_q;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din_q <= 8'h00;
            cnt_q     <= 32'd0;
            snap_q    <= 32'd0;
            halt_q    <= 1'b0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
        end else begin
            mem_din_q <= mem_din_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            halt_q    <= halt_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
        end
    end

    // Data storage: RAM and FIFO slots keep their contents across reset.
    always_ff @(posedge clk_in) begin
        if (ram_we_s) begin
            ram_q[ram_idx_s] <= bus.mem_dout;
        end
        if (rx_push_s) begin
            rx_mem_q[rx_wp_q[PW-2:0]] <= rx_data;
        end
        if (tx_push_s) begin
            tx_mem_q[tx_wp_q[PW-2:0]] <= tx_wdata_s;
        end
    end

    assign bus.mem_din = mem_din_q;
    assign bus.rdy_out = rdy_s;
    assign rx_ready    = !rx_full_s;
    assign tx_valid    = !tx_empty_s;
    assign tx_data     = tx_mem_q[tx_rp_q[PW-2:0]];
    assign halt        = halt_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: a reference model predicts read data
// and TX bytes; reads are queued on acceptance and compared when mem_din updates.
module tb_mem_io_responder;
    logic       clk_in, rst_in;
    logic       rx_valid, rx_ready, tx_valid, tx_ready, halt;
    logic [7:0] rx_data, tx_data;

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .bus      (bus.slave),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .halt     (halt)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  ram_m [int];
    logic [31:0] model_cnt;
    logic [31:0] snap_m;
    bit          halt_m;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Reference cycle counter: counts every clock from reset release.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) model_cnt <= 32'd0;
        else         model_cnt <= model_cnt + 32'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.mem_a    = 32'h0;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = 8'h00;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // One CPU access: wait for acceptance, update the model, check read data.
    task automatic cpu_op(input logic [31:0] a, input logic w, input logic [7:0] d);
        int         waited;
        logic [7:0] e;
        logic       io;
        logic [2:0] r;
        waited = 0;
        e  = 8'h00;
        io = (a[17:16] == 2'b11);
        r  = a[2:0];
        bus.mem_a = a; bus.mem_wr = w; bus.mem_dout = d;
        @(negedge clk_in);
        while (bus.rdy_out !== 1'b1 && waited < 100) begin
            waited++;
            @(negedge clk_in);
        end
        if (waited >= 100) begin
            check_val("accept_timeout", bus.rdy_out, 1);
            bus_idle();
            return;
        end
        if (!w) begin
            if (!io) begin
                e = ram_m.exists(int'(a[16:0])) ? ram_m[int'(a[16:0])] : 8'h00;
            end else begin
                case (r)
                    3'd0: e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
                    3'd4: begin snap_m = model_cnt; e = model_cnt[7:0]; end
                    3'd5: e = snap_m[15:8];
                    3'd6: e = snap_m[23:16];
                    3'd7: e = snap_m[31:24];
                    default: e = 8'h00;
                endcase
            end
        end else if (!io) begin
            ram_m[int'(a[16:0])] = d;
        end else if (!halt_m) begin
            if (r == 3'd0 && d != 8'h00) tx_q.push_back(d);
            else if (r == 3'd4) begin tx_q.push_back(8'h00); halt_m = 1'b1; end
        end
        @(posedge clk_in);
        if (!w) rd_q.push_back(e);
        #1;
        if (!w) check_val("rd_data", bus.mem_din, rd_q.pop_front());
        bus_idle();
    endtask

    task automatic peek_rdy(input string tag, input logic [31:0] a, input logic w,
                            input logic [7:0] d, input logic exp);
        bus.mem_a = a; bus.mem_wr = w; bus.mem_dout = d;
        #1;
        check_val(tag, bus.rdy_out, exp);
        bus_idle();
    endtask

    task automatic rx_send(input logic [7:0] b);
        int waited;
        waited = 0;
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk_in);
        while (rx_ready !== 1'b1 && waited < 100) begin
            waited++;
            @(negedge clk_in);
        end
        if (waited >= 100) check_val("rx_timeout", rx_ready, 1);
        @(posedge clk_in);
        if (waited < 100) rx_q.push_back(b);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic tx_drain();
        int k;
        k = 0;
        tx_ready = 1'b1;
        @(negedge clk_in);
        while (tx_valid === 1'b1 && k < 20) begin
            if (tx_q.size() == 0) check_val("tx_extra", tx_valid, 0);
            else                  check_val("tx_data", tx_data, tx_q.pop_front());
            k++;
            @(posedge clk_in);
            @(negedge clk_in);
        end
        tx_ready = 1'b0;
        check_val("tx_missing", tx_q.size(), 0);
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        bus_idle();
        snap_m = 32'd0; halt_m = 1'b0;
        idle_cycles(2);
        check_val("rst_mem_din", bus.mem_din, 8'h00);
        check_val("rst_rx_ready", rx_ready, 1);
        check_val("rst_tx_valid", tx_valid, 0);
        check_val("rst_halt", halt, 0);
        rst_in = 1'b1;
        idle_cycles(1);

        // RAM write/read-back, alias window, random locations
        cpu_op(32'h0000_0010, 1'b1, 8'hA5);
        cpu_op(32'h0000_0010, 1'b0, 8'h00);
        cpu_op(32'h0002_0010, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra;
            ra = {15'h0, 1'b0, 16'($urandom_range(32, 65535))};
            cpu_op(ra, 1'b1, 8'($urandom_range(1, 255)));
            cpu_op(ra | 32'h0002_0000, 1'b0, 8'h00);
        end

        // RX read stalls until a byte arrives
        fork
            cpu_op(32'h0003_0000, 1'b0, 8'h00);
            begin
                repeat (3) begin
                    @(posedge clk_in); #1;
                    check_val("rx_stall_rdy", bus.rdy_out, 0);
                end
                rx_send(8'h41);
            end
        join
        peek_rdy("rx_empty_again", 32'h0003_0000, 1'b0, 8'h00, 1'b0);

        // TX: zero data ignored, full FIFO stalls until a pop
        cpu_op(32'h0003_0000, 1'b1, 8'h48);
        cpu_op(32'h0003_0000, 1'b1, 8'h00);
        cpu_op(32'h0003_0000, 1'b1, 8'h49);
        for (int i = 0; i < 6; i++) cpu_op(32'h0003_0000, 1'b1, 8'h60 + 8'(i));
        peek_rdy("tx_full_rdy", 32'h0003_0000, 1'b1, 8'h70, 1'b0);
        peek_rdy("tx_full_zero_rdy", 32'h0003_0000, 1'b1, 8'h00, 1'b1);
        peek_rdy("tx_full_halt_rdy", 32'h0003_0004, 1'b1, 8'h00, 1'b0);
        fork
            cpu_op(32'h0003_0000, 1'b1, 8'h70);
            begin
                repeat (3) begin
                    @(posedge clk_in); #1;
                    check_val("tx_stall_rdy", bus.rdy_out, 0);
                end
                tx_ready = 1'b1;
                @(negedge clk_in);
                check_val("tx_head_valid", tx_valid, 1);
                check_val("tx_head_data", tx_data, tx_q.pop_front());
                @(posedge clk_in); #1;
                tx_ready = 1'b0;
            end
        join
        tx_drain();

        // Counter snapshot bytes; later byte reads keep the old snapshot
        idle_cycles(600);
        cpu_op(32'h0003_0004, 1'b0, 8'h00);
        cpu_op(32'h0003_0005, 1'b0, 8'h00);
        cpu_op(32'h0003_0006, 1'b0, 8'h00);
        cpu_op(32'h0003_0007, 1'b0, 8'h00);
        idle_cycles(300);
        cpu_op(32'h0003_0005, 1'b0, 8'h00);
        cpu_op(32'h0003_0001, 1'b0, 8'h00);

        // Reset mid-stream with queued RX and TX entries
        rx_send(8'h11); rx_send(8'h22); rx_send(8'h33);
        cpu_op(32'h0003_0000, 1'b1, 8'h5A);
        cpu_op(32'h0003_0000, 1'b1, 8'h5B);
        cpu_op(32'h0000_0010, 1'b0, 8'h00);
        rst_in = 1'b0;
        #1;
        check_val("mid_rst_rx_ready", rx_ready, 1);
        check_val("mid_rst_tx_valid", tx_valid, 0);
        check_val("mid_rst_halt", halt, 0);
        check_val("mid_rst_mem_din", bus.mem_din, 8'h00);
        rx_q.delete(); tx_q.delete(); rd_q.delete();
        snap_m = 32'd0; halt_m = 1'b0;
        idle_cycles(2);
        rst_in = 1'b1;
        idle_cycles(1);
        peek_rdy("post_rst_rx_empty", 32'h0003_0000, 1'b0, 8'h00, 1'b0);
        cpu_op(32'h0003_0005, 1'b0, 8'h00);
        cpu_op(32'h0000_0010, 1'b0, 8'h00);
        cpu_op(32'h0003_0004, 1'b0, 8'h00);

        // Halt: pushes 0x00, then I/O writes are ignored but RAM still works
        cpu_op(32'h0003_0004, 1'b1, 8'h99);
        check_val("halt_set", halt, 1);
        check_val("halt_tx_valid", tx_valid, 1);
        check_val("halt_tx_data", tx_data, 8'h00);
        cpu_op(32'h0003_0000, 1'b1, 8'h55);
        cpu_op(32'h0003_0004, 1'b1, 8'h01);
        cpu_op(32'h0000_0100, 1'b1, 8'h77);
        cpu_op(32'h0000_0100, 1'b0, 8'h00);
        tx_drain();
        check_val("halt_sticky", halt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
